lights_sequencer: RTL and testbench
===================================

LIGHTS_SEQUENCER -- requirements
Module: lights_sequencer

Interface
REQ-001 Parameter CW, default 8: bits per colour component; light width is 3*CW, packed {R,G,B}.
REQ-002 Parameter PERIOD, default 50: auto-step interval in clk cycles, legal range 2..2^16.
REQ-003 Parameter DEB_CYCLES, default 4: debounce length in cycles; used only when DEBOUNCE_EN is defined.
REQ-004 Port clk  input  1: single clock; all state updates on the rising edge.
REQ-005 Port rst  input  1: asynchronous, active-low reset.
REQ-006 Port button  input  1: step request, acted on at its rising edge.
REQ-007 Port dir  input  1: step direction (0 forward, 1 reverse).
REQ-008 Port auto_en  input  1: 1 enables the periodic auto-step.
REQ-009 Port sel  input  1: 1 forces white on light.
REQ-010 Port light  output  3*CW: registered colour output.
REQ-011 Port colour_idx  output  3: registered current state code.

Function
REQ-012 The state set SHALL be OFF=0, RED=1, YELLOW=2, GREEN=3, CYAN=4, BLUE=5, MAGENTA=6; code 7 is unused.
REQ-013 A rising edge is detected when the filtered button is high at edge k and was low at edge k-1; state and light SHALL update at edge k.
REQ-014 A forward step SHALL move OFF->RED->...->MAGENTA->RED; a reverse step SHALL move OFF->MAGENTA->...->RED->MAGENTA; OFF is never re-entered except by reset.
REQ-015 Each component SHALL be all-ones when active and zero otherwise: RED {1,0,0}, YELLOW {1,1,0}, GREEN {0,1,0}, CYAN {0,1,1}, BLUE {0,0,1}, MAGENTA {1,0,1}, OFF {0,0,0}.
REQ-016 While sel=1, light SHALL be all-ones; state keeps stepping, and light shows the state's colour at the first edge after sel falls.
REQ-017 Holding button high SHALL produce exactly one step; no step occurs without a new rising edge.
REQ-018 With auto_en=1, a tick SHALL fire every PERIOD cycles, counted from the edge auto_en is first sampled high; each tick steps in direction dir.
REQ-019 The auto timer SHALL restart from zero at every button-induced step and whenever auto_en=0.
REQ-020 A button edge and an auto tick in the same cycle SHALL cause exactly one step.
REQ-021 dir SHALL be sampled at the step edge; a dir change alone causes no step.

Reset
REQ-022 While rst=0, the block SHALL hold state OFF, light=0, colour_idx=0, timer=0, edge and debounce history=0, regardless of clk.
REQ-023 Reset deassertion with button already high SHALL NOT count as a rising edge.

Configuration
REQ-024 Macro LIGHTS_SEQUENCER_DEBOUNCE_EN defined: the filtered button SHALL change level only after the raw button has held the new level for DEB_CYCLES consecutive samples, adding DEB_CYCLES cycles of latency.
REQ-025 Macro undefined: the filtered button SHALL equal the raw button sampled once, and DEB_CYCLES SHALL have no effect.

Structure
REQ-026 Package lights_pkg SHALL hold the state enum, its 3-bit codes, and the colour-mask constants.
REQ-027 Debounce and edge detection SHALL be a sub-module, button_conditioner, exposing a single-cycle rise pulse.

Verification
REQ-028 Reset: hold rst=0 for 10 cycles with button toggling -> light=0, colour_idx=0 throughout.
REQ-029 Forward stepping: CW=8, dir=0, 7 single presses -> colour_idx 1,2,3,4,5,6,1 and light FF0000, FFFF00, 00FF00, 00FFFF, 0000FF, FF00FF, FF0000.
REQ-030 Reverse and held button: from OFF, dir=1, hold button high 20 cycles -> exactly one step, to colour_idx 6 and light FF00FF.
REQ-031 Auto mode: PERIOD=5, auto_en=1 for 30 cycles -> 6 steps, spaced exactly 5 cycles; a press at cycle 12 restarts spacing from that step.
REQ-032 Override: sel=1 during 2 presses starting from RED -> light FFFFFF; after sel=0 -> 00FF00.
REQ-033 Debounce, macro on, DEB_CYCLES=4: a 3-cycle button pulse causes no step; a 4-cycle pulse causes one step, 4 cycles after the raw rise.

Source files
------------

// File: rtl/lights_sequencer_pkg.sv
// lights_pkg: shared types for the lights sequencer.
//   colour_e     : 3-bit state codes (code 7 unused)
//   MASK_*       : per-colour component masks, packed {R,G,B}
//   colour_mask  : state -> component mask
//   colour_step  : state + direction -> next state
package lights_pkg;

  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_RED     = 3'd1,
    ST_YELLOW  = 3'd2,
    ST_GREEN   = 3'd3,
    ST_CYAN    = 3'd4,
    ST_BLUE    = 3'd5,
    ST_MAGENTA = 3'd6
  } colour_e;

  localparam logic [2:0] MASK_OFF     = 3'b000;
  localparam logic [2:0] MASK_RED     = 3'b100;
  localparam logic [2:0] MASK_YELLOW  = 3'b110;
  localparam logic [2:0] MASK_GREEN   = 3'b010;
  localparam logic [2:0] MASK_CYAN    = 3'b011;
  localparam logic [2:0] MASK_BLUE    = 3'b001;
  localparam logic [2:0] MASK_MAGENTA = 3'b101;

  function automatic logic [2:0] colour_mask(input colour_e s);
    case (s)
      ST_RED:     colour_mask = MASK_RED;
      ST_YELLOW:  colour_mask = MASK_YELLOW;
      ST_GREEN:   colour_mask = MASK_GREEN;
      ST_CYAN:    colour_mask = MASK_CYAN;
      ST_BLUE:    colour_mask = MASK_BLUE;
      ST_MAGENTA: colour_mask = MASK_MAGENTA;
      default:    colour_mask = MASK_OFF;
    endcase
  endfunction

  // OFF (and the unused code) only ever leaves; the ring RED..MAGENTA wraps.
  function automatic colour_e colour_step(input colour_e s, input logic rev);
    if (!rev) begin
      case (s)
        ST_RED:    colour_step = ST_YELLOW;
        ST_YELLOW: colour_step = ST_GREEN;
        ST_GREEN:  colour_step = ST_CYAN;
        ST_CYAN:   colour_step = ST_BLUE;
        ST_BLUE:   colour_step = ST_MAGENTA;
        default:   colour_step = ST_RED;
      endcase
    end else begin
      case (s)
        ST_MAGENTA: colour_step = ST_BLUE;
        ST_BLUE:    colour_step = ST_CYAN;
        ST_CYAN:    colour_step = ST_GREEN;
        ST_GREEN:   colour_step = ST_YELLOW;
        ST_YELLOW:  colour_step = ST_RED;
        default:    colour_step = ST_MAGENTA;
      endcase
    end
  endfunction

endpackage

// File: rtl/lights_sequencer_button_conditioner.sv
// button_conditioner: filters the raw button and emits a one-cycle rise pulse.
// Ports: clk, rst (async active-low), button (raw), rise (combinational pulse,
//        valid for the edge at which the filtered level is first seen high).
// Build option: LIGHTS_SEQUENCER_DEBOUNCE_EN -- filtered level only changes after
//   DEB_CYCLES consecutive raw samples at the new level (DEB_CYCLES extra latency).
//   Without it the filtered level is the raw button itself, sampled at the edge.
module button_conditioner #(
  parameter int unsigned DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic button,
  output logic rise
);

  if (DEB_CYCLES < 1) begin : g_deb_check
    $error("button_conditioner: DEB_CYCLES must be at least 1");
  end

  logic filt;
  logic filt_prev_q, filt_prev_d;
  logic armed_q, armed_d;

`ifdef LIGHTS_SEQUENCER_DEBOUNCE_EN
  localparam int unsigned DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DW-1:0] CNT_LAST = DW'(DEB_CYCLES - 1);

  logic          filt_q, filt_d;
  logic [DW-1:0] cnt_q, cnt_d;

  // cnt_q counts consecutive raw samples that disagree with the filtered level.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (button != filt_q) begin
      if (cnt_q == CNT_LAST) begin
        filt_d = button;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      filt_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign filt = filt_q;
`else
  assign filt = button;
`endif

  // armed_q blocks a button that is already held when reset releases: a rise
  // only counts once the raw button has been seen low since reset.
  always_comb begin
    filt_prev_d = filt;
    armed_d     = armed_q | ~button;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      filt_prev_q <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      filt_prev_q <= filt_prev_d;
      armed_q     <= armed_d;
    end
  end

  assign rise = armed_q & filt & ~filt_prev_q;

endmodule

// File: rtl/lights_sequencer.sv
// lights_sequencer: steps a colour state through OFF/RED/.../MAGENTA on button
// rising edges or a periodic auto tick, and drives a registered RGB light.
// Ports: clk, rst (async active-low), button (step request), dir (0 fwd, 1 rev),
//        auto_en (periodic step enable), sel (force white),
//        light [3*CW-1:0] {R,G,B}, colour_idx [2:0] (current state code).
// Build option: LIGHTS_SEQUENCER_DEBOUNCE_EN enables button debouncing.
//
// state   | meaning
// OFF     | after reset, never re-entered
// RED     | {1,0,0}
// YELLOW  | {1,1,0}
// GREEN   | {0,1,0}
// CYAN    | {0,1,1}
// BLUE    | {0,0,1}
// MAGENTA | {1,0,1}
module lights_sequencer
  import lights_pkg::*;
#(
  parameter int unsigned CW         = 8,
  parameter int unsigned PERIOD     = 50,
  parameter int unsigned DEB_CYCLES = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            button,
  input  logic            dir,
  input  logic            auto_en,
  input  logic            sel,
  output logic [3*CW-1:0] light,
  output logic [2:0]      colour_idx
);

  if (PERIOD < 2 || PERIOD > 65536) begin : g_period_check
    $error("lights_sequencer: PERIOD must be within 2..65536");
  end

  localparam int unsigned   TW     = $clog2(PERIOD);
  localparam logic [TW-1:0] T_LAST = TW'(PERIOD - 1);

  colour_e         state_q, state_d;
  logic [3*CW-1:0] light_q, light_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            btn_rise;
  logic            auto_tick;
  logic            step;
  logic [2:0]      mask;

  button_conditioner #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_btn (
    .clk   (clk),
    .rst   (rst),
    .button(button),
    .rise  (btn_rise)
  );

  // The timer counts sampled auto_en cycles; the edge it reaches PERIOD-1 is
  // the PERIOD-th one and fires the tick. Any step restarts it from zero, so a
  // coincident button edge and tick still produce a single step.
  always_comb begin
    auto_tick = auto_en && (timer_q == T_LAST);
    step      = btn_rise | auto_tick;
    state_d   = state_q;
    timer_d   = '0;
    if (step) begin
      state_d = colour_step(state_q, dir);
    end else if (auto_en) begin
      timer_d = timer_q + 1'b1;
    end
    mask    = colour_mask(state_d);
    light_d = sel ? '1 : {{CW{mask[2]}}, {CW{mask[1]}}, {CW{mask[0]}}};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_OFF;
      light_q <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      light_q <= light_d;
      timer_q <= timer_d;
    end
  end

  assign light      = light_q;
  assign colour_idx = state_q;

endmodule

// File: tb/tb_lights_sequencer.sv
module tb_lights_sequencer;

  localparam int CW     = 8;
  localparam int PERIOD = 5;
  localparam int DEB    = 4;
`ifdef LIGHTS_SEQUENCER_DEBOUNCE_EN
  localparam bit DEB_ON = 1'b1;
  localparam int LAT    = DEB;
`else
  localparam bit DEB_ON = 1'b0;
  localparam int LAT    = 0;
`endif

  localparam logic [23:0] PALETTE [0:6] = '{24'h000000, 24'hFF0000, 24'hFFFF00,
                                            24'h00FF00, 24'h00FFFF, 24'h0000FF, 24'hFF00FF};

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        button = 1'b0;
  logic        dir = 1'b0;
  logic        auto_en = 1'b0;
  logic        sel = 1'b0;
  logic [23:0] light;
  logic [2:0]  colour_idx;

  int checks = 0;
  int errors = 0;

  // reference model state
  int          m_idx;
  bit          m_seen_low;
  bit          m_prev;
  bit          m_filt;
  bit          m_filt_prev;
  int          m_elapsed;
  logic [23:0] m_light;
  bit          hist[$];

  logic [2:0]  last_obs;
  bit          obs_changed;
  int          chg[$];

  lights_sequencer #(
    .CW(CW), .PERIOD(PERIOD), .DEB_CYCLES(DEB)
  ) dut (
    .clk(clk), .rst(rst), .button(button), .dir(dir), .auto_en(auto_en),
    .sel(sel), .light(light), .colour_idx(colour_idx)
  );

  always #5 clk = ~clk;

  function automatic int next_idx(input int i, input bit rev);
    if (!rev) return (i == 0) ? 1 : (i % 6) + 1;
    return (i <= 1) ? 6 : i - 1;
  endfunction

  task automatic model_reset();
    m_idx = 0; m_seen_low = 0; m_prev = 0; m_filt = 0; m_filt_prev = 0;
    m_elapsed = 0; m_light = '0;
    hist.delete();
  endtask

  task automatic model_edge();
    bit rise, tick, same;
    if (!rst) begin
      model_reset();
      return;
    end
    if (DEB_ON) begin
      rise = m_seen_low && m_filt && !m_filt_prev;
      m_filt_prev = m_filt;
      hist.push_back(button);
      if (hist.size() > DEB) void'(hist.pop_front());
      if (hist.size() == DEB) begin
        same = 1;
        foreach (hist[k]) if (hist[k] != button) same = 0;
        if (same) m_filt = button;
      end
    end else begin
      rise = m_seen_low && button && !m_prev;
    end
    m_prev = button;
    if (!button) m_seen_low = 1;
    tick = 0;
    if (auto_en) begin
      m_elapsed++;
      tick = (m_elapsed == PERIOD);
    end
    if (!auto_en || rise || tick) m_elapsed = 0;
    if (rise || tick) m_idx = next_idx(m_idx, dir);
    m_light = sel ? 24'hFFFFFF : PALETTE[m_idx];
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_hex(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %06h expected %06h", tag, obs, exp);
    end
  endtask

  // One clock: advance model at the edge, compare 1 time unit later.
  task automatic step_cycle(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    checks++;
    assert (colour_idx === 3'(m_idx)) else begin
      errors++;
      $error("FAIL %s colour_idx observed %0d expected %0d", tag, colour_idx, m_idx);
    end
    checks++;
    assert (light === m_light) else begin
      errors++;
      $error("FAIL %s light observed %06h expected %06h", tag, light, m_light);
    end
    obs_changed = (colour_idx !== last_obs);
    last_obs = colour_idx;
  endtask

  // Asynchronous reset mid-cycle, checked before any clock edge.
  task automatic do_reset();
    #2;
    rst = 1'b0;
    button = 1'b0;
    auto_en = 1'b0;
    sel = 1'b0;
    model_reset();
    #1;
    check_int("async_rst_idx", int'(colour_idx), 0);
    check_hex("async_rst_light", light, 24'h0);
    repeat (3) step_cycle("in_reset");
    rst = 1'b1;
    repeat (3) step_cycle("post_reset");
  endtask

  task automatic press(input string tag);
    button = 1'b1;
    repeat (6) step_cycle(tag);
    button = 1'b0;
    repeat (6) step_cycle(tag);
  endtask

  initial begin
    int exp_idx [0:6];
    int exp_chg [0:5];
    logic [23:0] exp_light [0:6];
    exp_idx   = '{1, 2, 3, 4, 5, 6, 1};
    exp_light = '{24'hFF0000, 24'hFFFF00, 24'h00FF00, 24'h00FFFF,
                  24'h0000FF, 24'hFF00FF, 24'hFF0000};
    exp_chg   = '{4, 9, 12, 17, 22, 27};
    model_reset();
    last_obs = '0;

    // reset held with button toggling
    for (int i = 0; i < 10; i++) begin
      button = ~button;
      step_cycle("reset_hold");
      check_int("reset_idx_zero", int'(colour_idx), 0);
    end

    // release reset with button already high: no step
    button = 1'b1;
    rst = 1'b1;
    repeat (8) step_cycle("rst_release_held");
    check_int("held_at_reset_no_step", int'(colour_idx), 0);
    button = 1'b0;
    repeat (6) step_cycle("release");

    // forward stepping, seven presses
    dir = 1'b0;
    for (int i = 0; i < 7; i++) begin
      press("fwd_press");
      check_int("fwd_idx", int'(colour_idx), exp_idx[i]);
      check_hex("fwd_light", light, exp_light[i]);
    end

    // reverse with a long hold from OFF
    do_reset();
    dir = 1'b1;
    button = 1'b1;
    begin
      int n = 0;
      for (int i = 0; i < 20; i++) begin
        step_cycle("rev_hold");
        if (obs_changed) n++;
      end
      check_int("rev_hold_steps", n, 1);
    end
    check_int("rev_hold_idx", int'(colour_idx), 6);
    check_hex("rev_hold_light", light, 24'hFF00FF);
    button = 1'b0;
    repeat (6) step_cycle("rev_release");

    // override: white while stepping, colour after release
    do_reset();
    dir = 1'b0;
    press("ovr_to_red");
    check_int("ovr_start_red", int'(colour_idx), 1);
    sel = 1'b1;
    press("ovr_press1");
    press("ovr_press2");
    check_hex("ovr_white", light, 24'hFFFFFF);
    check_int("ovr_idx", int'(colour_idx), 3);
    sel = 1'b0;
    step_cycle("ovr_release");
    check_hex("ovr_after", light, 24'h00FF00);

    // auto stepping for 30 cycles
    do_reset();
    auto_en = 1'b1;
    chg.delete();
    for (int i = 0; i < 30; i++) begin
      step_cycle("auto");
      if (obs_changed) chg.push_back(i);
    end
    auto_en = 1'b0;
    check_int("auto_step_count", chg.size(), 6);
    for (int k = 1; k < chg.size(); k++) check_int("auto_spacing", chg[k] - chg[k-1], PERIOD);
    repeat (4) step_cycle("auto_off");

    // auto stepping with a press landing at cycle 12
    do_reset();
    auto_en = 1'b1;
    chg.delete();
    for (int i = 0; i < 30; i++) begin
      button = (i >= 12 - LAT) && (i < 12 - LAT + 6);
      step_cycle("auto_press");
      if (obs_changed) chg.push_back(i);
    end
    auto_en = 1'b0;
    button = 1'b0;
    check_int("auto_press_count", chg.size(), 6);
    for (int k = 0; k < 6 && k < chg.size(); k++) check_int("auto_press_when", chg[k], exp_chg[k]);
    repeat (6) step_cycle("auto_press_off");

    // short and threshold-length pulses
    do_reset();
    begin
      int n = 0;
      for (int j = 0; j < 11; j++) begin
        button = (j < 3);
        step_cycle("pulse3");
        if (obs_changed) n++;
      end
      check_int("pulse3_steps", n, DEB_ON ? 0 : 1);
    end
    chg.delete();
    for (int j = 0; j < 12; j++) begin
      button = (j < 4);
      step_cycle("pulse4");
      if (obs_changed) chg.push_back(j);
    end
    check_int("pulse4_steps", chg.size(), 1);
    if (chg.size() > 0) check_int("pulse4_latency", chg[0], LAT);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(3) == 0) button = ~button;
      dir     = 1'($urandom_range(1));
      auto_en = ($urandom_range(7) != 0);
      sel     = ($urandom_range(3) == 0);
      if ($urandom_range(149) == 0) do_reset();
      step_cycle("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
